// File: rtl/mu_particle_dispatch.sv
// mu_particle_dispatch: routes motion-updated particles either to the local
// position/velocity cache (home cell) or into a migration FIFO that feeds the
// inter-cell router over a valid/ready stream. One pass per MU_start.
// Optional feature macro: MU_DISPATCH_STATS_EN builds the per-pass local and
// migration counters; when undefined both count outputs are tied to 0.

package MD_pkg;
  localparam int PARTICLE_ID_WIDTH = 8;
  localparam int ELEMENT_WIDTH     = 2;
  localparam int MU_ID_WIDTH       = 4;
  typedef struct packed { logic [31:0] x, y, z; } offset_data_t;
  typedef struct packed { logic [31:0] x, y, z; } float_data_t;
endpackage

module mu_particle_dispatch
  import MD_pkg::*;
#(
  parameter int MIG_FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         MU_start,
  input  logic [PARTICLE_ID_WIDTH-1:0] i_num_particles,
  input  offset_data_t                 i_offset,
  input  float_data_t                  i_vel,
  input  logic [ELEMENT_WIDTH-1:0]     i_element,
  input  logic                         i_data_valid,
  input  logic [MU_ID_WIDTH-1:0]       i_MU_id,
  input  logic [1:0]                   i_cell_x_offset,
  input  logic [1:0]                   i_cell_y_offset,
  input  logic [1:0]                   i_cell_z_offset,
  output logic                         o_wr_en,
  output logic [PARTICLE_ID_WIDTH-1:0] o_wr_addr,
  output offset_data_t                 o_wr_offset,
  output float_data_t                  o_wr_vel,
  output logic [ELEMENT_WIDTH-1:0]     o_wr_element,
  output logic                         o_mig_valid,
  input  logic                         i_mig_ready,
  output offset_data_t                 o_mig_offset,
  output float_data_t                  o_mig_vel,
  output logic [ELEMENT_WIDTH-1:0]     o_mig_element,
  output logic [5:0]                   o_mig_dst,
  output logic [MU_ID_WIDTH-1:0]       o_mig_MU_id,
  output logic                         o_dispatch_done,
  output logic                         o_overflow,
  output logic                         o_illegal,
  output logic [PARTICLE_ID_WIDTH-1:0] o_local_count,
  output logic [PARTICLE_ID_WIDTH-1:0] o_mig_count
);

  localparam int AW = $clog2(MIG_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    offset_data_t                offset;
    float_data_t                 vel;
    logic [ELEMENT_WIDTH-1:0]    element;
    logic [5:0]                  dst;
    logic [MU_ID_WIDTH-1:0]      mu_id;
  } mig_entry_t;

  state_t                         state, state_nxt;
  logic [PARTICLE_ID_WIDTH-1:0]   n_lat, rx_cnt, wr_addr;
  mig_entry_t                     mem [MIG_FIFO_DEPTH];
  mig_entry_t                     head;
  logic [AW:0]                    wr_ptr, rd_ptr;
  logic                           empty, full;
  logic                           beat_ok, any_ill, is_local;
  logic                           loc_we, mig_req, push, pop, drop;

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A start cycle flushes, so a beat coinciding with it is not taken.
  assign beat_ok  = i_data_valid && (state == RUN) && !MU_start;
  assign any_ill  = (i_cell_x_offset == 2'b11) || (i_cell_y_offset == 2'b11) ||
                    (i_cell_z_offset == 2'b11);
  assign is_local = (i_cell_x_offset == 2'b01) && (i_cell_y_offset == 2'b01) &&
                    (i_cell_z_offset == 2'b01);
  assign loc_we   = beat_ok && !any_ill && is_local;
  assign mig_req  = beat_ok && !any_ill && !is_local;
  assign pop      = !empty && i_mig_ready;
  assign push     = mig_req && (!full || pop);
  assign drop     = mig_req && !push;

  // Next-state logic; MU_start from any state (re)enters RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (MU_start) state_nxt = RUN;
      RUN:   if (rx_cnt == n_lat) state_nxt = DRAIN;
      DRAIN: if (empty) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
    endcase
    if (MU_start) state_nxt = RUN;
  end

  // State, pass bookkeeping, sticky flags and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      n_lat           <= '0;
      rx_cnt          <= '0;
      wr_addr         <= '0;
      o_overflow      <= 1'b0;
      o_illegal       <= 1'b0;
      o_dispatch_done <= 1'b0;
    end else begin
      state           <= state_nxt;
      o_dispatch_done <= (state == DONE) && !MU_start;
      if (MU_start) begin
        n_lat      <= i_num_particles;
        rx_cnt     <= '0;
        wr_addr    <= '0;
        o_overflow <= 1'b0;
        o_illegal  <= 1'b0;
      end else begin
        if (beat_ok)                  rx_cnt     <= rx_cnt + 1'b1;
        if (loc_we)                   wr_addr    <= wr_addr + 1'b1;
        if (drop)                     o_overflow <= 1'b1;
        if (beat_ok && any_ill)       o_illegal  <= 1'b1;
      end
    end
  end

  // Local cache write port, one cycle after the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_offset  <= '0;
      o_wr_vel     <= '0;
      o_wr_element <= '0;
    end else begin
      o_wr_en <= loc_we;
      if (loc_we) begin
        o_wr_addr    <= wr_addr;
        o_wr_offset  <= i_offset;
        o_wr_vel     <= i_vel;
        o_wr_element <= i_element;
      end
    end
  end

  // Migration FIFO pointers; MU_start flushes.
  always_ff @(posedge clk) begin
    if (rst || MU_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Migration FIFO storage (no reset needed; payload is masked when empty).
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= '{offset:  i_offset,
                               vel:     i_vel,
                               element: i_element,
                               dst:     {i_cell_x_offset, i_cell_y_offset, i_cell_z_offset},
                               mu_id:   i_MU_id};
  end

  assign head          = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign o_mig_valid   = !empty;
  assign o_mig_offset  = head.offset;
  assign o_mig_vel     = head.vel;
  assign o_mig_element = head.element;
  assign o_mig_dst     = head.dst;
  assign o_mig_MU_id   = head.mu_id;

`ifdef MU_DISPATCH_STATS_EN
  // Saturating per-pass counters of local writes and accepted pushes.
  always_ff @(posedge clk) begin
    if (rst || MU_start) begin
      o_local_count <= '0;
      o_mig_count   <= '0;
    end else begin
      if (loc_we && (o_local_count != '1)) o_local_count <= o_local_count + 1'b1;
      if (push   && (o_mig_count   != '1)) o_mig_count   <= o_mig_count + 1'b1;
    end
  end
`else
  assign o_local_count = '0;
  assign o_mig_count   = '0;
`endif

endmodule

// File: tb/tb_mu_particle_dispatch.sv
// Directed bench for mu_particle_dispatch with a scoreboard for local writes
// and migration beats.
module tb_mu_particle_dispatch;
  import MD_pkg::*;

  localparam int DEPTH = 16;
  localparam int PW    = PARTICLE_ID_WIDTH;
  localparam int LW    = $bits(offset_data_t) + $bits(float_data_t) + ELEMENT_WIDTH;
  localparam int MW    = LW + 6 + MU_ID_WIDTH;

  logic                   clk = 1'b0;
  logic                   rst, MU_start, i_data_valid, i_mig_ready;
  logic [PW-1:0]          i_num_particles;
  offset_data_t           i_offset;
  float_data_t            i_vel;
  logic [ELEMENT_WIDTH-1:0] i_element;
  logic [MU_ID_WIDTH-1:0] i_MU_id;
  logic [1:0]             i_cell_x_offset, i_cell_y_offset, i_cell_z_offset;
  logic                   o_wr_en, o_mig_valid, o_dispatch_done, o_overflow, o_illegal;
  logic [PW-1:0]          o_wr_addr, o_local_count, o_mig_count;
  offset_data_t           o_wr_offset, o_mig_offset;
  float_data_t            o_wr_vel, o_mig_vel;
  logic [ELEMENT_WIDTH-1:0] o_wr_element, o_mig_element;
  logic [5:0]             o_mig_dst;
  logic [MU_ID_WIDTH-1:0] o_mig_MU_id;

  mu_particle_dispatch #(.MIG_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .MU_start(MU_start), .i_num_particles(i_num_particles),
    .i_offset(i_offset), .i_vel(i_vel), .i_element(i_element),
    .i_data_valid(i_data_valid), .i_MU_id(i_MU_id),
    .i_cell_x_offset(i_cell_x_offset), .i_cell_y_offset(i_cell_y_offset),
    .i_cell_z_offset(i_cell_z_offset),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_offset(o_wr_offset),
    .o_wr_vel(o_wr_vel), .o_wr_element(o_wr_element),
    .o_mig_valid(o_mig_valid), .i_mig_ready(i_mig_ready),
    .o_mig_offset(o_mig_offset), .o_mig_vel(o_mig_vel), .o_mig_element(o_mig_element),
    .o_mig_dst(o_mig_dst), .o_mig_MU_id(o_mig_MU_id),
    .o_dispatch_done(o_dispatch_done), .o_overflow(o_overflow), .o_illegal(o_illegal),
    .o_local_count(o_local_count), .o_mig_count(o_mig_count)
  );

  always #5 clk = ~clk;

  int              tests = 0;
  int              fails = 0;
  int              done_cnt = 0;
  logic [MW-1:0]   mig_q[$];
  logic            pend_v = 1'b0;
  logic [PW-1:0]   pend_addr, addr_m;
  logic [LW-1:0]   pend_data;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge, update the model, return #1 after posedge.
  task automatic step();
    logic [MW-1:0] got;
    @(negedge clk);
    chk("wr_en", 256'(o_wr_en), 256'(pend_v));
    if (pend_v) begin
      chk("wr_addr", 256'(o_wr_addr), 256'(pend_addr));
      chk("wr_data", 256'({o_wr_offset, o_wr_vel, o_wr_element}), 256'(pend_data));
    end
    if (o_dispatch_done) done_cnt++;
    if (o_mig_valid && i_mig_ready) begin
      got = {o_mig_offset, o_mig_vel, o_mig_element, o_mig_dst, o_mig_MU_id};
      tests++;
      assert (mig_q.size() != 0) else begin
        fails++;
        $error("FAIL mig_unexpected: observed %0h expected none", got);
      end
      if (mig_q.size() != 0) chk("mig_payload", 256'(got), 256'(mig_q.pop_front()));
    end
    pend_v = 1'b0;
    if (MU_start) begin
      mig_q.delete();
      addr_m = '0;
    end else if (i_data_valid) begin
      if (i_cell_x_offset == 2'b11 || i_cell_y_offset == 2'b11 || i_cell_z_offset == 2'b11) begin
        // dropped, flag only
      end else if (i_cell_x_offset == 2'b01 && i_cell_y_offset == 2'b01 && i_cell_z_offset == 2'b01) begin
        pend_v    = 1'b1;
        pend_addr = addr_m;
        pend_data = {i_offset, i_vel, i_element};
        addr_m    = addr_m + 1'b1;
      end else if (mig_q.size() < DEPTH) begin
        mig_q.push_back({i_offset, i_vel, i_element,
                         i_cell_x_offset, i_cell_y_offset, i_cell_z_offset, i_MU_id});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [PW-1:0] n);
    MU_start = 1'b1;
    i_num_particles = n;
    step();
    MU_start = 1'b0;
  endtask

  task automatic beat(input logic [1:0] cx, input logic [1:0] cy, input logic [1:0] cz);
    i_offset        = {$urandom, $urandom, $urandom};
    i_vel           = {$urandom, $urandom, $urandom};
    i_element       = ELEMENT_WIDTH'($urandom);
    i_MU_id         = MU_ID_WIDTH'($urandom);
    i_cell_x_offset = cx;
    i_cell_y_offset = cy;
    i_cell_z_offset = cz;
    i_data_valid    = 1'b1;
    step();
    i_data_valid    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 100 && done_cnt == d0; i++) step();
    chk(tag, 256'(done_cnt), 256'(d0 + 1));
    step();
    step();
    chk({tag, "_single"}, 256'(done_cnt), 256'(d0 + 1));
  endtask

  int d_before;
  int exp_lc, exp_mc;

  initial begin
    rst = 1'b1; MU_start = 1'b0; i_data_valid = 1'b0; i_mig_ready = 1'b1;
    i_num_particles = '0; i_offset = '0; i_vel = '0; i_element = '0; i_MU_id = '0;
    i_cell_x_offset = 2'b01; i_cell_y_offset = 2'b01; i_cell_z_offset = 2'b01;
    addr_m = '0; pend_addr = '0; pend_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en",   256'(o_wr_en), 256'(0));
    chk("rst_mig_vld", 256'(o_mig_valid), 256'(0));
    chk("rst_done",    256'(o_dispatch_done), 256'(0));
    chk("rst_flags",   256'({o_overflow, o_illegal}), 256'(0));
    chk("rst_counts",  256'({o_local_count, o_mig_count}), 256'(0));
    rst = 1'b0;

    // Local pass: addresses 0..3 back to back, no migration.
    start(4);
    repeat (4) beat(2'b01, 2'b01, 2'b01);
    wait_done("local_done");

    // Migration pass: +x, -x, home.
    start(3);
    beat(2'b10, 2'b01, 2'b01);
    beat(2'b00, 2'b01, 2'b01);
    beat(2'b01, 2'b01, 2'b01);
    wait_done("mig_done");
    chk("mig_q_empty", 256'(mig_q.size()), 256'(0));
`ifdef MU_DISPATCH_STATS_EN
    exp_lc = 1; exp_mc = 2;
`else
    exp_lc = 0; exp_mc = 0;
`endif
    chk("local_count", 256'(o_local_count), 256'(exp_lc));
    chk("mig_count",   256'(o_mig_count),   256'(exp_mc));

    // Backpressure and overflow.
    i_mig_ready = 1'b0;
    start(17);
    repeat (16) beat(2'b10, 2'b00, 2'b10);
    chk("ovf_before_full", 256'(o_overflow), 256'(0));
    beat(2'b10, 2'b00, 2'b10);
    chk("ovf_set", 256'(o_overflow), 256'(1));
    chk("model_q_16", 256'(mig_q.size()), 256'(16));
    d_before = done_cnt;
    repeat (5) step();
    chk("no_done_while_full", 256'(done_cnt), 256'(d_before));
    i_mig_ready = 1'b1;
    for (int i = 0; i < 40 && mig_q.size() != 0; i++) step();
    chk("drained", 256'(mig_q.size()), 256'(0));
    chk("no_done_before_last_pop", 256'(done_cnt), 256'(d_before));
    wait_done("ovf_done");
    chk("ovf_sticky", 256'(o_overflow), 256'(1));

    // Illegal beat counts toward N but is neither written nor pushed.
    start(2);
    chk("ovf_cleared", 256'(o_overflow), 256'(0));
    beat(2'b01, 2'b01, 2'b11);
    chk("illegal_set", 256'(o_illegal), 256'(1));
    beat(2'b01, 2'b01, 2'b01);
    wait_done("ill_done");

    // Restart mid-RUN with three queued entries, then an empty pass.
    i_mig_ready = 1'b0;
    start(10);
    beat(2'b01, 2'b01, 2'b11);
    repeat (3) beat(2'b01, 2'b10, 2'b01);
    chk("pre_restart_vld", 256'(o_mig_valid), 256'(1));
    chk("pre_restart_ill", 256'(o_illegal), 256'(1));
`ifdef MU_DISPATCH_STATS_EN
    exp_mc = 3;
`else
    exp_mc = 0;
`endif
    chk("pre_restart_mig_count", 256'(o_mig_count), 256'(exp_mc));
    start(0);
    chk("flush_vld",   256'(o_mig_valid), 256'(0));
    chk("flush_flags", 256'({o_overflow, o_illegal}), 256'(0));
    chk("flush_counts", 256'({o_local_count, o_mig_count}), 256'(0));
    wait_done("n0_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
